// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 target, oversampled in the clk domain.
// Receives MSB-first words and shifts a response word out on miso.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES);

  localparam logic [1:0] ARM   = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   cs_dly_q, cs_dly_d;
  logic [1:0]             state_q, state_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_shreg_q, rx_shreg_d;
  logic [DATA_W-1:0]      tx_shreg_q, tx_shreg_d;
  logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
  logic                   tx_full_q, tx_full_d;
  logic                   word_done_q, word_done_d;
  logic                   oe_q, oe_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall;
  logic              cs_rise, cs_fall;
  logic              word_start;
  logic [DATA_W-1:0] next_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // A load strobe coinciding with a word start bypasses tx_buf.
  assign next_word = tx_load   ? tx_data :
                     tx_full_q ? tx_buf_q : '1;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shreg_d  = rx_shreg_q;
    tx_shreg_d  = tx_shreg_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    word_done_d = 1'b0;
    oe_d        = oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    word_start  = 1'b0;

    if (tx_load) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
    if (rx_ack) rx_valid_d = 1'b0;
    if (ovr_clr) overrun_d = 1'b0;
    if (word_done_q) begin
      rx_data_d  = rx_shreg_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end

    unique case (state_q)
      ARM: begin
        // Let the synchronizers flush before trusting cs.
        if (arm_cnt_q != ARM_DONE) arm_cnt_d = arm_cnt_q + 1'b1;
        else if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          oe_d       = 1'b1;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          oe_d        = 1'b0;
          frame_err_d = (bit_cnt_q != '0);
        end else begin
          if (word_done_q) word_start = 1'b1;
          if (sclk_rise) begin
            rx_shreg_d = {rx_shreg_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_d   = '0;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (sclk_fall && bit_cnt_q != '0) begin
            tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = ARM;
    endcase

    if (word_start) begin
      tx_shreg_d = next_word;
      tx_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      state_q     <= ARM;
      arm_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      rx_shreg_q  <= '0;
      tx_shreg_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      word_done_q <= 1'b0;
      oe_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shreg_q  <= rx_shreg_d;
      tx_shreg_q  <= tx_shreg_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      word_done_q <= word_done_d;
      oe_q        <= oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = oe_q & tx_shreg_q[DATA_W-1];
  assign miso_oe   = oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: SPI master model driving spi_slave_rx,
// checked against a word-level reference model.
module tb_spi_slave_rx;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst, sclk, cs, mosi;
  logic          miso, miso_oe;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_load, rx_valid, rx_ack;
  logic          overrun, ovr_clr, frame_err, busy;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int lat;

  logic          m_tx_full;
  logic [DW-1:0] m_tx_val;
  logic          m_rx_valid;
  logic [DW-1:0] m_rx_data;
  logic          m_ovr;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .ovr_clr(ovr_clr),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) fe_cnt++;

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    m_tx_full = 1'b0; m_tx_val = '0;
    m_rx_valid = 1'b0; m_rx_data = '0; m_ovr = 1'b0;
  endtask

  task automatic m_start(output logic [DW-1:0] e);
    e = m_tx_full ? m_tx_val : 8'hFF;
    m_tx_full = 1'b0;
  endtask

  task automatic m_done(input logic [DW-1:0] w, input bit ack_same);
    if (m_rx_valid && !ack_same) m_ovr = 1'b1;
    m_rx_valid = 1'b1;
    m_rx_data = w;
  endtask

  task automatic load_tx(input logic [DW-1:0] v);
    tx_data = v; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    m_tx_full = 1'b1; m_tx_val = v;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_rx_valid = 1'b0;
  endtask

  task automatic do_clr();
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(4);
    cs = 1'b1;
    tick(8);
  endtask

  // Sends the top n bits of w; miso is captured at each rising edge.
  task automatic spi_bits(input logic [DW-1:0] w, input int n,
                          input int h, input bit ack_last,
                          output logic [DW-1:0] got);
    got = '0;
    lat = -1;
    for (int i = 0; i < n; i++) begin
      mosi = w[DW-1-i];
      tick(h);
      got[DW-1-i] = miso;
      sclk = 1'b1;
      for (int k = 1; k <= h; k++) begin
        @(negedge clk);
        if (i == n - 1) begin
          if (lat < 0 && rx_valid === 1'b1) lat = k;
          rx_ack = (ack_last && k == SS + 1);
        end
      end
      rx_ack = 1'b0;
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0; ovr_clr = 1'b0;
    m_reset();
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({miso, miso_oe, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rst_pins got=%b exp=000", {miso, miso_oe, busy});
    end
    checks++;
    if ({rx_valid, overrun, frame_err} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=000",
               {rx_valid, overrun, frame_err});
    end
    checks++;
    if (rx_data !== m_rx_data) begin
      failures++;
      $display("FAIL rst_data got=%h exp=%h", rx_data, m_rx_data);
    end
    tick(4);
  endtask

  task automatic test_basic();
    logic [DW-1:0] e, got;
    int fe0;
    load_tx(8'h3C);
    cs_low();
    m_start(e);
    spi_bits(8'hA5, 8, 4, 1'b0, got);
    m_done(8'hA5, 1'b0);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL basic_miso got=%h exp=%h", got, e);
    end
    checks++;
    if (lat !== SS + 2) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, SS + 2);
    end
    checks++;
    if (rx_data !== m_rx_data || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_rx got=%h/%b exp=%h/1",
               rx_data, rx_valid, m_rx_data);
    end
    checks++;
    if ({busy, miso_oe} !== 2'b11) begin
      failures++;
      $display("FAIL basic_busy got=%b exp=11", {busy, miso_oe});
    end
    fe0 = fe_cnt;
    cs_high();
    checks++;
    if (fe_cnt !== fe0 || {busy, miso_oe, miso} !== 3'b000) begin
      failures++;
      $display("FAIL basic_end fe=%0d pins=%b exp fe=%0d pins=000",
               fe_cnt - fe0, {busy, miso_oe, miso}, 0);
    end
    do_ack();
    checks++;
    if (rx_valid !== m_rx_valid) begin
      failures++;
      $display("FAIL basic_ack got=%b exp=%b", rx_valid, m_rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [2];
    logic [DW-1:0] e, got;
    words[0] = 8'h01;
    words[1] = 8'hFE;
    cs_low();
    for (int j = 0; j < 2; j++) begin
      m_start(e);
      spi_bits(words[j], 8, 4 + j, 1'b0, got);
      m_done(words[j], 1'b0);
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL b2b_miso%0d got=%h exp=%h", j, got, e);
      end
      checks++;
      if (rx_data !== m_rx_data || rx_valid !== 1'b1 || lat !== SS + 2) begin
        failures++;
        $display("FAIL b2b_rx%0d got=%h/%b/%0d exp=%h/1/%0d",
                 j, rx_data, rx_valid, lat, m_rx_data, SS + 2);
      end
      do_ack();
    end
    cs_high();
    checks++;
    if (overrun !== m_ovr || rx_valid !== m_rx_valid) begin
      failures++;
      $display("FAIL b2b_flags got=%b%b exp=%b%b",
               overrun, rx_valid, m_ovr, m_rx_valid);
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] e, got;
    cs_low();
    m_start(e);
    spi_bits(8'h11, 8, 4, 1'b0, got);
    m_done(8'h11, 1'b0);
    m_start(e);
    spi_bits(8'h22, 8, 4, 1'b0, got);
    m_done(8'h22, 1'b0);
    cs_high();
    checks++;
    if (rx_data !== m_rx_data || overrun !== m_ovr || m_ovr !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set got=%h/%b exp=%h/%b",
               rx_data, overrun, m_rx_data, m_ovr);
    end
    tick(5);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky got=%b exp=1", overrun);
    end
    do_clr();
    checks++;
    if (overrun !== m_ovr) begin
      failures++;
      $display("FAIL ovr_clr got=%b exp=%b", overrun, m_ovr);
    end
    do_ack();
  endtask

  task automatic test_truncated();
    logic [DW-1:0] e, got;
    int fe0;
    cs_low();
    m_start(e);
    spi_bits(8'($urandom), 5, 4, 1'b0, got);
    fe0 = fe_cnt;
    cs_high();
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      failures++;
      $display("FAIL trunc_ferr got=%0d cycles exp=1", fe_cnt - fe0);
    end
    checks++;
    if (rx_valid !== m_rx_valid || got[7:3] !== e[7:3]) begin
      failures++;
      $display("FAIL trunc_rx got=%b/%h exp=%b/%h",
               rx_valid, got[7:3], m_rx_valid, e[7:3]);
    end
    cs_low();
    m_start(e);
    spi_bits(8'h5A, 8, 4, 1'b0, got);
    m_done(8'h5A, 1'b0);
    checks++;
    if (rx_data !== m_rx_data || rx_valid !== 1'b1 || got !== e) begin
      failures++;
      $display("FAIL trunc_next got=%h/%b/%h exp=%h/1/%h",
               rx_data, rx_valid, got, m_rx_data, e);
    end
    cs_high();
    do_ack();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e, got;
    cs_low();
    spi_bits(8'hFF, 3, 4, 1'b0, got);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    tick(8);
    spi_bits(8'hFF, 5, 4, 1'b0, got);
    tick(6);
    checks++;
    if ({rx_valid, busy, miso_oe} !== 3'b000) begin
      failures++;
      $display("FAIL arm_hold got=%b exp=000", {rx_valid, busy, miso_oe});
    end
    cs_high();
    cs_low();
    m_start(e);
    spi_bits(8'hC3, 8, 4, 1'b0, got);
    m_done(8'hC3, 1'b0);
    checks++;
    if (rx_data !== m_rx_data || rx_valid !== 1'b1 || got !== e) begin
      failures++;
      $display("FAIL arm_rx got=%h/%b/%h exp=%h/1/%h",
               rx_data, rx_valid, got, m_rx_data, e);
    end
    cs_high();
    do_ack();
  endtask

  task automatic test_collisions();
    logic [DW-1:0] e, got, w1, w2;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    cs_low();
    m_start(e);
    spi_bits(w1, 8, 4, 1'b0, got);
    m_done(w1, 1'b0);
    m_start(e);
    spi_bits(w2, 8, 4, 1'b1, got);
    m_done(w2, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== m_rx_data || overrun !== m_ovr) begin
      failures++;
      $display("FAIL ack_collide got=%b/%h/%b exp=1/%h/%b",
               rx_valid, rx_data, overrun, m_rx_data, m_ovr);
    end
    cs_high();
    do_ack();
    cs = 1'b0;
    tick(2);
    tx_data = 8'h81; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    tick(3);
    e = 8'h81;
    spi_bits(8'h00, 8, 4, 1'b0, got);
    m_done(8'h00, 1'b0);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL load_bypass got=%h exp=%h", got, e);
    end
    do_ack();
    m_start(e);
    spi_bits(8'h00, 8, 4, 1'b0, got);
    m_done(8'h00, 1'b0);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL bypass_empty got=%h exp=%h", got, e);
    end
    cs_high();
    do_ack();
  endtask

  task automatic test_random();
    logic [DW-1:0] e, got, w;
    int h, nw;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      h = $urandom_range(4, 6);
      nw = $urandom_range(1, 3);
      cs_low();
      for (int j = 0; j < nw; j++) begin
        m_start(e);
        w = 8'($urandom);
        spi_bits(w, 8, h, 1'b0, got);
        m_done(w, 1'b0);
        checks++;
        if (got !== e || rx_data !== m_rx_data || rx_valid !== m_rx_valid
            || overrun !== m_ovr) begin
          failures++;
          $display("FAIL rand_f%0d_w%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b",
                   f, j, got, rx_data, rx_valid, overrun,
                   e, m_rx_data, m_rx_valid, m_ovr);
        end
        if ($urandom_range(0, 1) == 1) do_ack();
        if ($urandom_range(0, 3) == 0) load_tx(8'($urandom));
      end
      cs_high();
      if ($urandom_range(0, 1) == 1) do_clr();
      checks++;
      if (overrun !== m_ovr || rx_valid !== m_rx_valid || busy !== 1'b0) begin
        failures++;
        $display("FAIL rand_end%0d got=%b/%b/%b exp=%b/%b/0",
                 f, overrun, rx_valid, busy, m_ovr, m_rx_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_truncated();
    test_reset_mid();
    test_collisions();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI mode-0 target (slave) that receives MSB-first words from an external SPI master over sclk/mosi/cs.
- Returns a response word on miso.
- Oversamples all SPI pins in the clk domain, presents each received word with a valid/ack handshake, and reports overrun and truncated frames.
- Sits opposite the team's SPI transmit controller and is used to loop back and check its output on-board.

Parameters:
- DATA_W, 8: bits per word, and the width of rx_data and tx_data.
- SYNC_STAGES, 2: synchronizer flops on sclk, mosi and cs (minimum 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from master; asynchronous to clk; idle low.
- cs  input  1  chip select, active low; asynchronous.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  1 while selected; the top level tristates miso when 0.
- tx_data  input  DATA_W  response word.
- tx_load  input  1  one-cycle strobe that writes tx_data into tx_buf.
- rx_data  output  DATA_W  last received word.
- rx_valid  output  1  rx_data is new; held until acknowledged.
- rx_ack  input  1  consumer acknowledge; clears rx_valid.
- overrun  output  1  sticky flag; a word completed while rx_valid was still 1.
- ovr_clr  input  1  clears overrun.
- frame_err  output  1  one-cycle pulse when cs deasserts mid-word.
- busy  output  1  1 in SHIFT.

Behaviour:
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0. Synchronizers reset to sclk=0 and cs=1. tx_buf is empty. The state goes to ARM.
- sclk, cs and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk/cs against one further delayed copy. mosi uses an equal delay so it stays aligned with sclk.
- Timing requirement on the master: sclk high and low times of at least SYNC_STAGES+2 clk periods. Faster sclk is outside spec.
- FSM state ARM: wait for synchronized cs=1, then go to IDLE. After reset mid-frame, this prevents joining a frame part-way through.
- FSM state IDLE: on synchronized cs falling, go to SHIFT. On entry:
  - bit_cnt=0.
  - The shift register loads tx_buf, or all-ones if tx_buf is empty, and tx_buf is marked empty.
  - miso_oe=1, and miso drives bit DATA_W-1 from the same cycle.
- FSM state SHIFT, rising sclk: shift mosi in at the LSB end and increment bit_cnt.
- FSM state SHIFT, falling sclk: miso advances to the next bit. No shift happens on the falling edge that follows the last rising edge of a word; the word-boundary reload covers that case.
- Word completion is the DATA_W-th rising edge, with bit_cnt wrapping to 0. On the next clk:
  - rx_data takes the full word and rx_valid=1.
  - If rx_valid was already 1 and rx_ack is not asserted this cycle, overrun=1 and rx_data is overwritten.
  - The shift register reloads from tx_buf (or all-ones) for the next word, and miso updates immediately.
  - The state stays SHIFT.
- cs rising in SHIFT: go to IDLE, miso_oe=0, miso=0.
  - If bit_cnt≠0: pulse frame_err for one cycle, discard the partial word, no rx_valid.
  - If bit_cnt=0: no error.
- Latency: rx_valid rises 1 clk after the synchronized final rising sclk, which is SYNC_STAGES+2 clk after the pin edge.
- rx_ack clears rx_valid on the next clk. If a word completes in the same cycle as rx_ack, the completion wins: rx_valid stays 1 with the new data and overrun is unchanged.
- ovr_clr clears overrun. If ovr_clr and a new overrun occur in the same cycle, overrun stays set.
- tx_load marks tx_buf full, and may arrive in any state. If tx_load arrives in the same cycle as a word-start load, tx_data bypasses tx_buf straight into the shift register and tx_buf stays empty.
- rst in any state returns to the reset values and ARM on the next clk, regardless of sclk/cs activity.

Test Plan:
1. Basic RX: tx_load 0x3C, cs low, master sends 0xA5 at sclk = clk/8, cs high.
   - Required: rx_data=0xA5, rx_valid=1 (SYNC_STAGES+2 clk after the 8th rising sclk), miso bits 0,0,1,1,1,1,0,0, no frame_err.
2. Back-to-back: words 0x01 then 0xFE in one cs frame, rx_ack after each word, tx_buf left empty.
   - Required: two rx_valid events in order, miso=0xFF for both words, overrun=0.
3. Overrun: send 0x11 then 0x22 with no rx_ack.
   - Required: rx_data=0x22, overrun=1, overrun held until ovr_clr, then 0.
4. Truncated frame: cs high after 5 sclk rising edges.
   - Required: one-cycle frame_err, rx_valid stays 0, next full frame 0x5A received correctly.
5. Reset mid-frame: rst pulse after 3 bits with cs held low, then 8 more clocks, then cs high, cs low, 0xC3.
   - Required: nothing received until cs toggles (ARM), then rx_data=0xC3.
6. Boundary collisions:
   - rx_ack in the same clk as word completion: rx_valid stays 1, no overrun.
   - tx_load 0x81 in the same clk as cs-fall detection: miso sends 0x81.
